// File: rtl/dsp_acc_sequencer.sv
// rtl/dsp_acc_sequencer.sv - clken/mode/dsp_reset sequencer for one cascade accumulator DSP column
// Tracks beat tags through the DSP latency and flags when P holds a finished TAPS-term sum.
module dsp_acc_sequencer #(
   parameter int TAPS     = 4,
   parameter int DSP_LAT  = 3,
   parameter int MODE_DLY = 1,
   parameter int GRP_W    = 16
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             flush,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             acc_clken,
   output logic             acc_mode,
   output logic             acc_dsp_reset,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [GRP_W-1:0] m_group,
   output logic             busy
);
   localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(TAPS - 1);

   logic [CW-1:0]       r_bcnt;
   logic [DSP_LAT-1:0]  r_tok_v;
   logic [DSP_LAT-1:0]  r_tok_l;
   logic [MODE_DLY-1:0] r_mode;
   logic                r_dsp_rst;
   logic [GRP_W-1:0]    r_group;

   logic w_stall;
   logic w_accept;
   logic w_drain;
   logic w_clken;
   logic w_flush;
   logic w_any_last;
   logic w_last_beat;
   logic w_mode_tag;

   assign m_valid     = r_tok_v[DSP_LAT-1] & r_tok_l[DSP_LAT-1];
   assign w_stall     = m_valid & ~m_ready;
   assign s_ready     = ~w_stall & ~r_dsp_rst & ~flush;
   assign w_accept    = s_valid & s_ready;
   // The output stage is left out so a finished result parked in P does not keep pulsing the column.
   assign w_any_last  = |(r_tok_v[DSP_LAT-2:0] & r_tok_l[DSP_LAT-2:0]);
   assign w_drain     = ~w_accept & ~w_stall & (r_bcnt == '0) & w_any_last;
   assign w_clken     = w_accept | w_drain;
   assign w_flush     = flush & ~r_dsp_rst;
   assign w_last_beat = (r_bcnt == LAST_BEAT);
   assign w_mode_tag  = w_accept & (r_bcnt != '0);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_bcnt    <= '0;
         r_tok_v   <= '0;
         r_tok_l   <= '0;
         r_mode    <= '0;
         r_group   <= '0;
         r_dsp_rst <= 1'b1;
      end else begin
         r_dsp_rst <= w_flush;
         if (w_flush) begin
            r_bcnt  <= '0;
            r_tok_v <= '0;
            r_tok_l <= '0;
            r_mode  <= '0;
            r_group <= '0;
         end else begin
            if (w_accept) begin
               r_bcnt <= w_last_beat ? '0 : r_bcnt + 1'b1;
            end
            if (w_clken) begin
               r_tok_v <= (r_tok_v << 1) | DSP_LAT'(w_accept);
               r_tok_l <= (r_tok_l << 1) | DSP_LAT'(w_accept & w_last_beat);
               r_mode  <= (r_mode << 1) | MODE_DLY'(w_mode_tag);
               // Counts retirements: a result held in P while the input idles is counted once.
               if (m_valid & m_ready) begin
                  r_group <= r_group + 1'b1;
               end
            end
         end
      end
   end

   assign acc_clken     = w_clken;
   assign acc_mode      = r_mode[MODE_DLY-1];
   assign acc_dsp_reset = r_dsp_rst;
   assign m_group       = r_group;
   assign busy          = (r_bcnt != '0) | (|r_tok_v);

endmodule

// File: tb/tb_dsp_acc_sequencer.sv
// tb/tb_dsp_acc_sequencer.sv - bench for dsp_acc_sequencer with a DSP column model and group-queue reference
module tb_dsp_acc_sequencer;
   localparam int TAPS = 4;

   logic        clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        flush = 1'b0;
   logic        s_valid = 1'b0;
   logic        m_ready = 1'b1;
   logic        s_ready, acc_clken, acc_mode, acc_dsp_reset, m_valid, busy;
   logic [15:0] m_group;
   int unsigned s_data = 0;
   int          errors = 0;
   int          checks = 0;

   dsp_acc_sequencer #(.TAPS(TAPS), .DSP_LAT(3), .MODE_DLY(1), .GRP_W(16)) dut (
      .clk(clk), .aresetn(aresetn), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
      .acc_clken(acc_clken), .acc_mode(acc_mode), .acc_dsp_reset(acc_dsp_reset),
      .m_valid(m_valid), .m_ready(m_ready), .m_group(m_group), .busy(busy)
   );

   always #5 clk = ~clk;

   // DSP column: A1, A2, OPMODE reg and P, all gated by clken
   int unsigned a1 = 0, a2 = 0, p = 0;
   logic        opm = 1'b0;
   always @(posedge clk) begin
      if (acc_dsp_reset) begin
         a1 <= 0; a2 <= 0; opm <= 1'b0; p <= 0;
      end else if (acc_clken) begin
         a1  <= (s_valid && s_ready) ? s_data : 0;
         a2  <= a1;
         opm <= acc_mode;
         p   <= (opm ? p : 0) + a2;
      end
   end

   // Reference: beat position, running sum, queue of finished groups with pulses left to reach P
   typedef struct {int unsigned sum; int rem;} grp_t;
   grp_t        q[$];
   int          m_b;
   int unsigned m_sum;
   logic [15:0] m_grp;
   bit          m_rst, m_mode;
   bit          e_mv, e_acc, e_clk;
   logic [5:0]  e_vec;

   function automatic logic [5:0] obs();
      return {s_ready, acc_clken, acc_mode, acc_dsp_reset, m_valid, busy};
   endfunction

   task automatic model_clear();
      m_b = 0; m_sum = 0; q.delete(); m_grp = '0; m_mode = 0;
   endtask

   task automatic drive(input bit sv, input bit mr, input bit fl, input int unsigned d);
      bit stall, pend;
      @(negedge clk);
      s_valid = sv; m_ready = mr; flush = fl; s_data = d;
      #1;
      e_mv  = (q.size() != 0) && (q[0].rem == 0);
      stall = e_mv && !mr;
      e_acc = sv && !stall && !m_rst && !fl;
      pend  = 0;
      foreach (q[i]) if (q[i].rem > 0) pend = 1;
      e_clk = e_acc || (!e_acc && !stall && m_b == 0 && pend);
      e_vec = {!stall && !m_rst && !fl, e_clk, m_mode, m_rst, e_mv, (m_b != 0) || (q.size() != 0)};
   endtask

   task automatic tick();
      grp_t g;
      @(posedge clk);
      if (!aresetn || (flush && !m_rst)) begin
         model_clear(); m_rst = 1;
         return;
      end
      m_rst = 0;
      if (e_clk) begin
         if (e_mv) begin q.delete(0); m_grp = m_grp + 1'b1; end
         foreach (q[i]) if (q[i].rem > 0) q[i].rem = q[i].rem - 1;
         m_mode = e_acc && (m_b != 0);
         if (e_acc) begin
            m_sum = (m_b == 0) ? s_data : m_sum + s_data;
            if (m_b == TAPS - 1) begin g.sum = m_sum; g.rem = 2; q.push_back(g); end
            m_b = (m_b + 1) % TAPS;
         end
      end
   endtask

   task automatic test_reset();
      model_clear(); m_rst = 1;
      for (int c = 0; c < 4; c++) begin
         drive(0, 1, 0, 0);
         checks++; if (obs() !== e_vec) begin errors++; $display("FAIL reset c%0d outs got=%b want=%b", c, obs(), e_vec); end
         checks++; if (m_group !== m_grp) begin errors++; $display("FAIL reset_grp c%0d got=%0d want=%0d", c, m_group, m_grp); end
         if (c == 0) begin checks++; if (obs() !== 6'b000100) begin errors++; $display("FAIL reset_state got=%b want=000100", obs()); end end
         if (c == 1) begin checks++; if (acc_dsp_reset !== 1'b1) begin errors++; $display("FAIL reset_extra_clk dsp_reset got=%b want=1", acc_dsp_reset); end end
         if (c == 2) begin checks++; if ({s_ready, acc_dsp_reset} !== 2'b10) begin errors++; $display("FAIL reset_release got=%b want=10", {s_ready, acc_dsp_reset}); end end
         tick();
         if (c == 0) #2 aresetn = 1'b1;
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      for (int c = 0; c < 14; c++) begin
         drive(c < 8, 1, 0, $urandom_range(1, 1000));
         checks++; if (obs() !== e_vec) begin errors++; $display("FAIL b2b c%0d outs got=%b want=%b", c, obs(), e_vec); end
         checks++; if (m_group !== m_grp) begin errors++; $display("FAIL b2b_grp c%0d got=%0d want=%0d", c, m_group, m_grp); end
         if (e_mv) begin checks++; if (p !== q[0].sum) begin errors++; $display("FAIL b2b_p c%0d got=%0d want=%0d", c, p, q[0].sum); end end
         if (c >= 1 && c <= 8) begin
            checks++; if (acc_mode !== ((c - 1) % TAPS != 0)) begin errors++; $display("FAIL b2b_mode c%0d got=%b want=%b", c, acc_mode, (c - 1) % TAPS != 0); end
         end
         if (c == 6 || c == 10) begin
            checks++; if (m_valid !== 1'b1 || m_group !== 16'((c - 6) / 4)) begin errors++; $display("FAIL b2b_out c%0d valid=%b grp=%0d want 1,%0d", c, m_valid, m_group, (c - 6) / 4); end
         end
         if (c >= 8 && acc_clken === 1'b1) pulses++;
         tick();
      end
      checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_drain pulses got=%0d want=2", pulses); end
   endtask

   task automatic test_drain();
      int pulses = 0;
      for (int c = 0; c < 10; c++) begin
         drive(c < 4, 1, 0, c + 1);
         checks++; if (obs() !== e_vec) begin errors++; $display("FAIL drain c%0d outs got=%b want=%b", c, obs(), e_vec); end
         checks++; if (m_group !== m_grp) begin errors++; $display("FAIL drain_grp c%0d got=%0d want=%0d", c, m_group, m_grp); end
         if (c >= 4 && acc_clken === 1'b1) pulses++;
         tick();
      end
      checks++; if (pulses != 2) begin errors++; $display("FAIL drain_pulses got=%0d want=2", pulses); end
      @(negedge clk); #1;
      checks++; if (m_valid !== 1'b1 || p !== 10 || acc_clken !== 1'b0) begin errors++; $display("FAIL drain_sum valid=%b p=%0d clken=%b want 1,10,0", m_valid, p, acc_clken); end
   endtask

   task automatic test_stall();
      for (int c = 0; c < 12; c++) begin
         drive(c < 9, c >= 5, 0, $urandom_range(1, 1000));
         checks++; if (obs() !== e_vec) begin errors++; $display("FAIL stall c%0d outs got=%b want=%b", c, obs(), e_vec); end
         if (e_mv) begin checks++; if (p !== q[0].sum) begin errors++; $display("FAIL stall_p c%0d got=%0d want=%0d", c, p, q[0].sum); end end
         if (c < 5) begin
            checks++; if (s_ready !== 1'b0 || acc_clken !== 1'b0 || p !== 10) begin errors++; $display("FAIL stall_hold c%0d rdy=%b clken=%b p=%0d want 0,0,10", c, s_ready, acc_clken, p); end
         end
         if (c == 5) begin
            checks++; if (s_ready !== 1'b1 || acc_clken !== 1'b1) begin errors++; $display("FAIL stall_resume rdy=%b clken=%b want 1,1", s_ready, acc_clken); end
         end
         tick();
      end
   endtask

   task automatic test_starve();
      int unsigned sum_a = 0, sum_b = 0, d;
      for (int c = 0; c < 18; c++) begin
         d = $urandom_range(1, 1000);
         if (c < 4) sum_a += d;
         else if (c < 6 || (c >= 10 && c < 12)) sum_b += d;
         drive(c < 6 || (c >= 10 && c < 12), 1, 0, d);
         checks++; if (obs() !== e_vec) begin errors++; $display("FAIL starve c%0d outs got=%b want=%b", c, obs(), e_vec); end
         checks++; if (m_group !== m_grp) begin errors++; $display("FAIL starve_grp c%0d got=%0d want=%0d", c, m_group, m_grp); end
         if (c >= 6 && c < 10) begin
            checks++; if (acc_clken !== 1'b0 || m_valid !== 1'b1 || p !== sum_a) begin errors++; $display("FAIL starve_hold c%0d clken=%b valid=%b p=%0d want 0,1,%0d", c, acc_clken, m_valid, p, sum_a); end
         end
         tick();
      end
      @(negedge clk); #1;
      checks++; if (m_valid !== 1'b1 || p !== sum_b) begin errors++; $display("FAIL starve_sum valid=%b p=%0d want 1,%0d", m_valid, p, sum_b); end
   endtask

   task automatic test_flush();
      for (int c = 0; c < 14; c++) begin
         drive(c < 8, 1, c == 2 || c == 3, (c < 4) ? c + 1 : c + 1);
         checks++; if (obs() !== e_vec) begin errors++; $display("FAIL flush c%0d outs got=%b want=%b", c, obs(), e_vec); end
         checks++; if (m_group !== m_grp) begin errors++; $display("FAIL flush_grp c%0d got=%0d want=%0d", c, m_group, m_grp); end
         if (c == 2) begin checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b want=0", s_ready); end end
         if (c == 3) begin
            checks++; if (acc_dsp_reset !== 1'b1 || m_group !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL flush_clear rst=%b grp=%0d busy=%b want 1,0,0", acc_dsp_reset, m_group, busy); end
         end
         if (c == 4) begin checks++; if (acc_dsp_reset !== 1'b0) begin errors++; $display("FAIL flush_once dsp_reset got=%b want=0", acc_dsp_reset); end end
         tick();
      end
      @(negedge clk); #1;
      checks++; if (m_valid !== 1'b1 || p !== 26 || m_group !== 16'd0) begin errors++; $display("FAIL flush_sum valid=%b p=%0d grp=%0d want 1,26,0", m_valid, p, m_group); end
   endtask

   task automatic test_async_reset();
      for (int c = 0; c < 2; c++) begin
         drive(1, 1, 0, $urandom_range(1, 1000));
         checks++; if (obs() !== e_vec) begin errors++; $display("FAIL areset_pre c%0d outs got=%b want=%b", c, obs(), e_vec); end
         tick();
      end
      @(negedge clk); #3 aresetn = 1'b0; #1;
      checks++; if (obs() !== 6'b000100 || m_group !== 16'd0) begin errors++; $display("FAIL areset_now outs=%b grp=%0d want 000100,0", obs(), m_group); end
      tick();
      #2 aresetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         drive(0, 1, 0, 0);
         checks++; if (obs() !== e_vec) begin errors++; $display("FAIL areset_post c%0d outs got=%b want=%b", c, obs(), e_vec); end
         if (c == 1) begin checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%b want=1", s_ready); end end
         tick();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, $urandom_range(1, 1000));
         checks++; if (obs() !== e_vec) begin errors++; $display("FAIL rand c%0d outs got=%b want=%b", c, obs(), e_vec); end
         checks++; if (m_group !== m_grp) begin errors++; $display("FAIL rand_grp c%0d got=%0d want=%0d", c, m_group, m_grp); end
         if (e_mv) begin checks++; if (p !== q[0].sum) begin errors++; $display("FAIL rand_p c%0d got=%0d want=%0d", c, p, q[0].sum); end end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_drain();
      test_stall();
      test_starve();
      test_flush();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dsp_acc_sequencer.md
# dsp_acc_sequencer

Sequencer for one cascade accumulator column of the bicubic interpolator: DSP_ADD3_CIN feeding DSP_ACC_CASCADE_CIN. It accepts tap beats over a valid/ready handshake and drives the shared `clken`, `mode` and `dsp_reset` of the column. It also drains the DSP pipeline and flags when the accumulator output P holds a finished TAPS-term sum. It sits between the coefficient/pixel fetch logic and the output pixel packer.

## Interface
- TAPS, 4: terms accumulated per output sample (2..16).
- DSP_LAT, 3: clken pulses from a beat at the DSP A:B input until its result is in P (AREG=2, PREG=1).
- MODE_DLY, 1: clken pulses between a beat and its mode value at the DSP mode input (OPMODEREG=1).
- GRP_W, 16: width of the output group counter.
- clk  in  1  single clock.
- aresetn  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous soft clear, one-cycle pulse.
- s_valid  in  1  upstream beat valid; op0/cin/pc_in are driven by upstream in the same cycle.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- acc_clken  out  1  clken to every DSP in the column.
- acc_mode  out  1  mode to DSP_ACC_CASCADE_CIN.
- acc_dsp_reset  out  1  dsp_reset to every DSP in the column.
- m_valid  out  1  P holds a finished sum.
- m_ready  in  1  downstream consumed P.
- m_group  out  GRP_W  index of the group currently flagged by m_valid.
- busy  out  1  open group or tokens in flight.

## Operation
- **Beat counter** `bcnt`, range 0..TAPS-1.
  - Increments on each accept; wraps to 0 after the TAPS-th beat.
  - The beat accepted with `bcnt==0` is a group's first beat and is tagged mode=0; all other beats are tagged mode=1.
  - The beat accepted with `bcnt==TAPS-1` is tagged last.
- **Token pipe.** A DSP_LAT-deep shift register of {valid, last} advances only on `acc_clken`.
  - Stage 0 loads the accepted beat's tags, or {0,0} on a drain pulse.
- **Mode pipe.** A MODE_DLY-deep shift register of mode tags, also advancing on `acc_clken`.
  - `acc_mode` is its output.
  - Drain pulses insert mode=0.
- **Output flag.** `m_valid` = last stage valid && last.
  - `m_group` increments, wrapping modulo 2^GRP_W, when m_valid && m_ready.
- **Output stall.** `stall = m_valid && !m_ready`.
  - While stalled, `s_ready` = 0 and `acc_clken` = 0, so P is frozen.
- **Pulse rule.** `s_ready = !stall && !acc_dsp_reset && !flush`, and `acc_clken = accept || drain`.
- **Drain.** `drain = !accept && !stall && bcnt==0 && any_last_in_pipe`.
  - A bubble is never inserted inside an open group. If upstream starves mid-group, the whole column stalls, including the previous group's in-flight result.
- **Reset.**
  - During aresetn low: all counters and pipes are 0, `acc_dsp_reset`=1, every other output is 0.
  - After release, `acc_dsp_reset` stays 1 for exactly one more clk, then drops.
- **Flush.** Sets `acc_dsp_reset`=1 in the next cycle and clears `bcnt`, both pipes and `m_group`. In-flight partial sums are discarded.
  - flush has priority over a simultaneous accept (`s_ready` is already 0).
  - A flush pulse arriving while `acc_dsp_reset` is already 1 has no extra effect.
- **busy** = `bcnt!=0` || any token valid.

## Timing
- A beat accepted at edge k is in A1 at k and A2 at pulse k+1. Its mode reaches the OPMODE register at pulse k+1. Its sum enters P at pulse k+2 (DSP_LAT=3 pulses counting k).
- Back-to-back beats, m_ready=1:
  - The first output asserts m_valid 2 clk after the last beat is accepted.
  - Sustained throughput is one output per TAPS clk with no bubbles.
- m_valid is registered-stage derived, not combinational from m_ready.
- m_valid falls on the pulse following consumption unless the next stage is also last.
- Group g's m_valid and group g+1's accept may coincide: allowed when m_ready=1.
- A drain completes a last group in DSP_LAT-1 = 2 extra pulses when the input is idle.

## Test plan
- TAPS=4, reset release, 8 beats back-to-back, m_ready=1 -> acc_mode sequence 0,1,1,1,0,1,1,1 at the DSP input with delay 1. m_valid high at clk 5 and clk 9 after the first accept. m_group 0 then 1.
- 4 beats then s_valid=0 -> 2 drain pulses on acc_clken. m_valid=1 holds; acc_clken=0 afterward. With DSP model inputs 1,2,3,4 and pc_in=0, P=10.
- m_ready=0 for 5 clk while m_valid=1 with s_valid=1 -> s_ready=0, acc_clken=0, P unchanged. On m_ready=1, the accept resumes that same clk.
- s_valid drops after beat 2 of a group while the previous group's last is in flight -> no drain pulse. P is unchanged until beat 3 arrives. Both sums are correct.
- flush during beat 3 of a group -> acc_dsp_reset=1 for 1 clk. bcnt=0, m_group=0. The next 4 beats produce a clean sum.
- aresetn low mid-group for 1 clk asynchronously -> all outputs 0 and acc_dsp_reset=1 immediately. 1 clk after release, s_ready=1.
